hilo_muldiv: RTL
================

# hilo_muldiv

Parametrised, multi-cycle multiply/divide unit with HI/LO registers for the E stage of the five-stage MIPS pipeline. It supports signed and unsigned mult, div, and multiply-accumulate/subtract, plus mthi/mtlo. It reports `busy` so hazard control can stall `mfhi`/`mflo` and further md ops. It aborts cleanly on an exception, and width and latencies are configurable.

## Interface
- `WIDTH`, 32, operand/HI/LO width (≥ 8)
- `MULT_CYCLES`, 5, busy cycles for mult/madd/maddu/msub (≥ 1)
- `DIV_CYCLES`, 10, busy cycles for div/divu (≥ 1)

- `clk`  in  1  single clock, all state on rising edge
- `reset`  in  1  asynchronous, active-high; clears all state
- `issue`  in  1  E-stage md instruction valid (not stalled, not bubble)
- `op`  in  3  000 none, 001 mult, 010 multu, 011 div, 100 divu, 101 madd, 110 maddu, 111 msub
- `a`, `b`  in  WIDTH  forwarded rs/rt operands
- `moveto`  in  2  00 none, 01 mthi, 10 mtlo, 11 reserved (no-op)
- `cancel`  in  1  exception/flush from CP0
- `start`  out  1  combinational; high in the cycle an op is accepted
- `busy`  out  1  registered; op in flight
- `hi`, `lo`  out  WIDTH  architectural HI/LO
- `div_zero`  out  1  registered one-cycle pulse when a div/divu with `b == 0` completes

## Operation
- FSM states are IDLE, RUN_MUL and RUN_DIV. A down-counter of width clog2(max(MULT_CYCLES, DIV_CYCLES))+1 runs alongside.
- `start = issue && op != 0 && !busy && !cancel`.
- **On accept:**
  - Latch the operation result into the pending registers `p_hi`/`p_lo`.
  - Load the counter with N−1, where N is the op's latency.
  - Enter RUN_MUL or RUN_DIV.
- **Results:**
  - mult/multu: full 2·WIDTH product, signed or unsigned.
  - madd/maddu: {hi,lo} + product. msub: {hi,lo} − signed product. Arithmetic is modulo 2^(2·WIDTH), using {hi,lo} as of the accept cycle.
  - div/divu: lo = quotient, hi = remainder. Truncation is toward zero and the remainder takes the dividend's sign.
  - Signed MIN ÷ −1: lo = MIN, hi = 0.
- **Divide by zero:** hi/lo are left unchanged on completion and `div_zero` pulses.
- **Completion:** when the counter is 0 in a RUN state, commit p_hi/p_lo to hi/lo and return to IDLE.
- **`issue` while busy:** ignored. The hazard unit must stall; a bench assertion flags it.
- **`moveto`:** applied only when `!busy && !start && !cancel`. It writes `a` to hi (01) or lo (10).
- **Same cycle issue + moveto:** the issue wins and moveto is dropped.
- **`cancel` in IDLE:** blocks that cycle's accept and moveto.
- **`cancel` in a RUN state:** return to IDLE at the next edge. Pending results are discarded, hi/lo are unchanged and no `div_zero` pulse is issued.
- **`reset` (any time, including mid-operation):** hi = lo = 0, IDLE, busy = 0, div_zero = 0, counter = 0, pending registers = 0.

## Timing
- Accept at cycle T (`start` = 1).
- `busy` is 1 in cycles T+1 … T+N and 0 at T+N+1.
- New hi/lo are visible from T+N+1. `div_zero` is high in cycle T+N+1 only.
- Back-to-back operation: a new op can be accepted in cycle T+N+1.
- moveto at cycle T: hi/lo are updated and visible from T+1.
- `cancel` at cycle T+k (1 ≤ k ≤ N): busy = 0 from T+k+1 and hi/lo keep their pre-op values.
- `start` has a combinational path from `issue`/`op`/`cancel`. All other outputs come directly from flops.

## Structure
- Package `muldiv_pkg` holds:
  - the op enum (MD_NONE … MD_MSUB) and moveto enum (MT_NONE, MT_HI, MT_LO);
  - the FSM state enum;
  - the function `md_lat(op)` returning MULT_CYCLES or DIV_CYCLES.
- Sub-module `muldiv_arith`: purely combinational, parametrised by WIDTH. It takes op, a, b, hi, lo and produces {res_hi, res_lo, dz}. The top level holds the FSM, counter, pending registers and HI/LO.

## Test plan
- **mult signed:** reset, then mult a=0xFFFFFFFE (−2), b=3 → start for 1 cycle, busy for 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- **div/divu:** divu 7/2 → after 10 busy cycles lo=3, hi=1. div −7/2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF. div 0x80000000/−1 → lo=0x80000000, hi=0.
- **Divide by zero and accumulate:** mthi 0x1, mtlo 0x2, then div 5/0 → hi=1, lo=2 unchanged and div_zero pulses for 1 cycle. Then madd 2×3 → hi=1, lo=8. Then msub 1×9 → hi=0, lo=0xFFFFFFFF.
- **Cancel:** mult 3×4 with cancel asserted in busy cycle 3 → busy low the next cycle and hi/lo unchanged. Issue and cancel in the same cycle → start=0 and no state change.
- **Concurrency:**
  - Issue during busy → ignored and the assertion fires.
  - Issue + mtlo in the same cycle → only the op takes effect.
  - Async reset pulse mid-div (between edges) → hi=lo=0 and busy=0 immediately.
- **Parameter sweep:** WIDTH=16, MULT_CYCLES=1, DIV_CYCLES=3. multu 0xFFFF×0xFFFF → hi=0xFFFE, lo=0x0001 after 1 busy cycle. A random self-checking run against a reference model covers all ops.

Source files
------------

// File: rtl/muldiv_pkg.sv
// Shared types for the HI/LO multiply/divide unit.
// Op and moveto encodings, FSM states and latency selection.
package muldiv_pkg;

    typedef enum logic [2:0] {
        MD_NONE  = 3'b000,
        MD_MULT  = 3'b001,
        MD_MULTU = 3'b010,
        MD_DIV   = 3'b011,
        MD_DIVU  = 3'b100,
        MD_MADD  = 3'b101,
        MD_MADDU = 3'b110,
        MD_MSUB  = 3'b111
    } md_op_e;

    typedef enum logic [1:0] {
        MT_NONE = 2'b00,
        MT_HI   = 2'b01,
        MT_LO   = 2'b10,
        MT_RSVD = 2'b11
    } mt_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN_MUL,
        ST_RUN_DIV
    } md_state_e;

    function automatic logic md_is_div(input logic [2:0] op);
        return (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic int md_lat(input logic [2:0] op,
                                  input int mult_cycles,
                                  input int div_cycles);
        return md_is_div(op) ? div_cycles : mult_cycles;
    endfunction

endpackage

// File: rtl/muldiv_arith.sv
// Combinational datapath: product, accumulate and divide.
// Signed divide works on magnitudes, then restores signs.
module muldiv_arith
    import muldiv_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] hi,
    input  logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] res_hi,
    output logic [WIDTH-1:0] res_lo,
    output logic             dz
);

    localparam int W2 = 2 * WIDTH;

    logic [W2-1:0]    ext_as, ext_bs, ext_au, ext_bu;
    logic [W2-1:0]    prod_s, prod_u, acc, wide;
    logic [WIDTH-1:0] div_b, uq, ur;
    logic [WIDTH-1:0] mag_a, mag_b, mq, mr, sq, sr;
    logic             b_zero;

    // Evaluate every candidate result and select by op
    always_comb begin
        ext_as = {{WIDTH{a[WIDTH-1]}}, a};
        ext_bs = {{WIDTH{b[WIDTH-1]}}, b};
        ext_au = {{WIDTH{1'b0}}, a};
        ext_bu = {{WIDTH{1'b0}}, b};
        prod_s = ext_as * ext_bs;
        prod_u = ext_au * ext_bu;
        acc    = {hi, lo};
        b_zero = (b == '0);

        // divisor forced to 1 on zero so no X leaks
        div_b = b_zero ? WIDTH'(1) : b;
        uq    = a / div_b;
        ur    = a % div_b;

        mag_a = a[WIDTH-1] ? -a : a;
        mag_b = b[WIDTH-1] ? -b : b;
        if (b_zero) begin
            mag_b = WIDTH'(1);
        end
        mq = mag_a / mag_b;
        mr = mag_a % mag_b;
        sq = (a[WIDTH-1] ^ b[WIDTH-1]) ? -mq : mq;
        sr = a[WIDTH-1] ? -mr : mr;

        wide = acc;
        dz   = 1'b0;
        unique case (1'b1)
            (op == MD_MULT):  wide = prod_s;
            (op == MD_MULTU): wide = prod_u;
            (op == MD_MADD):  wide = acc + prod_s;
            (op == MD_MADDU): wide = acc + prod_u;
            (op == MD_MSUB):  wide = acc - prod_s;
            (op == MD_DIV): begin
                dz = b_zero;
                if (!b_zero) wide = {sr, sq};
            end
            (op == MD_DIVU): begin
                dz = b_zero;
                if (!b_zero) wide = {ur, uq};
            end
            default: wide = acc;
        endcase

        res_hi = wide[W2-1:WIDTH];
        res_lo = wide[WIDTH-1:0];
    end

endmodule

// File: rtl/hilo_muldiv.sv
// HI/LO multiply/divide unit for the E stage.
// Result is computed at accept; the FSM only models latency.
module hilo_muldiv
    import muldiv_pkg::*;
#(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             issue,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       moveto,
    input  logic             cancel,
    output logic             start,
    output logic             busy,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic             div_zero
);

    localparam int MAX_CYC =
        (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CW = $clog2(MAX_CYC) + 1;

    md_state_e        state_q, state_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] hi_q, lo_q, p_hi, p_lo;
    logic [WIDTH-1:0] res_hi, res_lo;
    logic             p_dz, res_dz;
    logic             busy_q, dz_q, commit, mt_ok;

    assign start    = issue && (op != MD_NONE) && !busy_q && !cancel;
    assign mt_ok    = !busy_q && !start && !cancel;
    assign busy     = busy_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign div_zero = dz_q;

    muldiv_arith #(.WIDTH(WIDTH)) u_arith (
        .op    (op),
        .a     (a),
        .b     (b),
        .hi    (hi_q),
        .lo    (lo_q),
        .res_hi(res_hi),
        .res_lo(res_lo),
        .dz    (res_dz)
    );

    // Next-state and latency counter control
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        commit  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = md_is_div(op) ? ST_RUN_DIV : ST_RUN_MUL;
                    cnt_d   = CW'(md_lat(op, MULT_CYCLES, DIV_CYCLES) - 1);
                end
            end
            ST_RUN_MUL, ST_RUN_DIV: begin
                if (cancel) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CW'(1);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // FSM state, counter and busy flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= (state_d != ST_IDLE);
        end
    end

    // Pending result captured on accept
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            p_hi <= '0;
            p_lo <= '0;
            p_dz <= 1'b0;
        end else if (start) begin
            p_hi <= res_hi;
            p_lo <= res_lo;
            p_dz <= res_dz;
        end
    end

    // Architectural HI/LO, moveto writes and div_zero pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            hi_q <= '0;
            lo_q <= '0;
            dz_q <= 1'b0;
        end else begin
            dz_q <= commit && p_dz;
            if (commit) begin
                if (!p_dz) begin
                    hi_q <= p_hi;
                    lo_q <= p_lo;
                end
            end else if (mt_ok) begin
                unique case (1'b1)
                    (moveto == MT_HI): hi_q <= a;
                    (moveto == MT_LO): lo_q <= a;
                    default: ;
                endcase
            end
        end
    end

endmodule
